// File: rtl/array_result_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : array_result_drain_pkg
// Purpose  : Shared accelerator constants and the drain occupancy type, so
//            the PE array and the result drain agree on tile geometry.
// Revision : 1.0 - initial release
// ============================================================================
package array_result_drain_pkg;

  localparam int TILE_SIZE_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF  = 32;
  localparam int FRAC_BITS_DEF  = 8;

  // Number of tiles held in the ping-pong buffer (0..2).
  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

endpackage : array_result_drain_pkg
`default_nettype wire

// File: rtl/requant_sat.sv
`default_nettype none
// ============================================================================
// Module   : requant_sat
// Purpose  : Combinational round-half-up, arithmetic right shift and signed
//            saturation of one accumulator element to the output width.
// Revision : 1.0 - initial release
// ============================================================================
module requant_sat
  import array_result_drain_pkg::*;
#(
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] q
);

  // Rounding constant is half an LSB of the result; zero when nothing is shifted out.
  localparam int RND_POS = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] C_ROUND =
    (FRAC_BITS > 0) ? ((ACC_WIDTH+1)'(1) << RND_POS) : '0;

  // Saturation bounds sign-extended to the widened intermediate.
  localparam logic signed [ACC_WIDTH:0] C_MAX =
    {{(ACC_WIDTH+2-DATA_WIDTH){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] C_MIN =
    {{(ACC_WIDTH+2-DATA_WIDTH){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH:0] w_sum;
  logic signed [ACC_WIDTH:0] w_shifted;

  // One extra bit keeps the rounding add from wrapping near the positive limit.
  always_comb begin
    w_sum     = {acc[ACC_WIDTH-1], acc} + C_ROUND;
    w_shifted = w_sum >>> FRAC_BITS;
    if (w_shifted > C_MAX) begin
      q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (w_shifted < C_MIN) begin
      q = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      q = w_shifted[DATA_WIDTH-1:0];
    end
  end

endmodule : requant_sat
`default_nettype wire

// File: rtl/array_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : array_result_drain
// Purpose  : Captures requantised result tiles from the PE array into a
//            two-slot ping-pong buffer and streams them out row by row with
//            valid/ready handshaking. Dropped tiles raise a sticky flag.
// Revision : 1.0 - initial release
// ============================================================================
module array_result_drain
  import array_result_drain_pkg::*;
#(
  parameter int TILE_SIZE  = TILE_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  localparam int IDX_W     = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic signed [ACC_WIDTH-1:0]  result_in [TILE_SIZE][TILE_SIZE],
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_row [TILE_SIZE],
  output logic [IDX_W-1:0]             out_row_idx,
  output logic                         out_last,
  output logic                         overflow_err
);

  localparam logic [IDX_W-1:0] C_LAST_ROW = IDX_W'(TILE_SIZE - 1);

  logic signed [DATA_WIDTH-1:0] w_q   [TILE_SIZE][TILE_SIZE];
  logic signed [DATA_WIDTH-1:0] r_mem [2][TILE_SIZE][TILE_SIZE];

  occ_t             r_occ;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [IDX_W-1:0] r_row;
  logic             r_ovf;

  logic w_hs;
  logic w_final;
  logic w_accept;
  logic w_drop;

  // Requantisation happens at capture so the buffer holds output-width data.
  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_row
    for (genvar j = 0; j < TILE_SIZE; j++) begin : g_col
      requant_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
      ) u_requant (
        .acc (result_in[i][j]),
        .q   (w_q[i][j])
      );
    end
  end

  // Handshake decode; a retiring tile frees its slot for a same-cycle capture.
  always_comb begin
    w_hs     = out_valid & out_ready;
    w_final  = w_hs & out_last;
    w_accept = valid_in & ((r_occ < OCC_FULL) | w_final);
    w_drop   = valid_in & ~w_accept;
  end

  // Tile storage is not reset; empty slots hold don't-care data.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < TILE_SIZE; i++) begin
        for (int j = 0; j < TILE_SIZE; j++) begin
          r_mem[r_wr_ptr][i][j] <= w_q[i][j];
        end
      end
    end
  end

  // Pointers, occupancy, row counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ    <= OCC_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_row    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_hs) begin
        r_row <= w_final ? '0 : r_row + IDX_W'(1);
      end
      if (w_final) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_accept, w_final})
        2'b10:   r_occ <= r_occ + occ_t'(1);
        2'b01:   r_occ <= r_occ - occ_t'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Output presentation from registered state; zeros while nothing is valid.
  always_comb begin
    out_valid    = (r_occ != OCC_EMPTY);
    in_ready     = (r_occ < OCC_FULL);
    overflow_err = r_ovf;
    out_last     = out_valid & (r_row == C_LAST_ROW);
    out_row_idx  = out_valid ? r_row : '0;
    for (int c = 0; c < TILE_SIZE; c++) begin
      out_row[c] = out_valid ? r_mem[r_rd_ptr][r_row][c] : '0;
    end
  end

endmodule : array_result_drain
`default_nettype wire

// File: tb/tb_array_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_result_drain
// Purpose  : Randomised and directed bench for array_result_drain with a
//            tile-level reference model feeding a row scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_result_drain;

  localparam int T  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int FB = 8;

  typedef logic signed [AW-1:0] tile_t [T][T];
  typedef struct packed {
    logic [T*DW-1:0] d;
    logic [1:0]      idx;
    logic            last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 valid_in = 1'b0;
  tile_t                result_in;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] out_row [T];
  logic [1:0]           out_row_idx;
  logic                 out_last;
  logic                 overflow_err;

  array_result_drain #(
    .TILE_SIZE (T), .DATA_WIDTH (DW), .ACC_WIDTH (AW), .FRAC_BITS (FB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .result_in    (result_in),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .out_row_idx  (out_row_idx),
    .out_last     (out_last),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_tot  = 0;
  exp_t sb[$];

  // Tile-level model: number of buffered tiles and row position of the oldest.
  int m_tiles = 0;
  int m_row   = 0;
  bit m_ovf   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Round half up, floor-divide by 2^FB, clamp to the output range.
  function automatic logic signed [DW-1:0] ref_q(input logic signed [AW-1:0] x);
    longint v, q, scale;
    scale = longint'(1) << FB;
    v = longint'(x) + (scale / 2);
    if (v >= 0) q = v / scale;
    else        q = -((-v + scale - 1) / scale);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return DW'(q);
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++)
        case ($urandom_range(0, 3))
          0:       t[i][j] = $urandom;
          1:       t[i][j] = $signed($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000;
          2:       t[i][j] = $signed($urandom_range(0, 4095)) - 32'sd2048;
          default: t[i][j] = $signed($urandom_range(0, 32'h01FF_FFFF)) - 32'sh0100_0000;
        endcase
    return t;
  endfunction

  task automatic push_tile(input tile_t t);
    exp_t e;
    for (int r = 0; r < T; r++) begin
      for (int c = 0; c < T; c++) e.d[c*DW +: DW] = ref_q(t[r][c]);
      e.idx  = 2'(r);
      e.last = (r == T-1);
      sb.push_back(e);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from tile-level rules.
  task automatic cycle(input bit v, input tile_t t, input bit rdy);
    bit hs, fin, acc;
    @(negedge clk);
    valid_in  = v;
    result_in = t;
    out_ready = rdy;
    #1;
    chk("in_ready",     64'(in_ready),     64'(m_tiles < 2));
    chk("out_valid",    64'(out_valid),    64'(m_tiles > 0));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    hs  = (m_tiles > 0) && rdy;
    fin = hs && (m_row == T-1);
    acc = v && ((m_tiles < 2) || fin);
    if (acc) push_tile(t);
    else if (v) m_ovf = 1'b1;
    if (hs) m_row = fin ? 0 : m_row + 1;
    m_tiles = m_tiles + int'(acc) - int'(fin);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_in_ready",  64'(in_ready),     64'd1);
    chk("rst_ovf",       64'(overflow_err), 64'd0);
    m_tiles = 0;
    m_row   = 0;
    m_ovf   = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every valid row is compared with the scoreboard head; pop on handshake.
  initial begin : monitor
    logic [T*DW-1:0] act;
    exp_t            e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        for (int c = 0; c < T; c++) act[c*DW +: DW] = out_row[c];
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_row", 64'(out_valid), 64'd0);
          end else begin
            e = sb[0];
            chk("row_data", 64'(act),         64'(e.d));
            chk("row_idx",  64'(out_row_idx), 64'(e.idx));
            chk("row_last", 64'(out_last),    64'(e.last));
            if (out_ready) void'(sb.pop_front());
          end
        end else begin
          chk("idle_row", {60'd0, out_last, out_row_idx, 1'b0} | 64'(act), 64'd0);
        end
      end
    end
  end

  initial begin : stim
    tile_t t;
    tile_t z;
    int    guard;
    for (int i = 0; i < T; i++) for (int j = 0; j < T; j++) z[i][j] = '0;
    result_in = z;

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_in_ready",  64'(in_ready),     64'd1);
    chk("rst_ovf",       64'(overflow_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rounding and saturation corners, then back-to-back capture with ready high.
    t = rand_tile();
    t[0][0] = 32'sd384;
    t[0][1] = -32'sd384;
    t[0][2] = 32'sd127;
    t[0][3] = 32'h7FFF_FFFF;
    t[1][0] = 32'h8000_0000;
    t[1][1] = 32'sd32767 <<< 8;
    cycle(1'b1, t, 1'b1);
    cycle(1'b1, rand_tile(), 1'b1);
    for (int k = 0; k < 9; k++) cycle(1'b0, z, 1'b1);

    // Simultaneous: full buffer, new tile on the final-row handshake.
    cycle(1'b1, rand_tile(), 1'b0);
    cycle(1'b1, rand_tile(), 1'b0);
    guard = 0;
    while (!(m_tiles == 2 && m_row == T-1) && guard < 20) begin
      cycle(1'b0, z, 1'b1);
      guard++;
    end
    chk("simul_setup", 64'(guard < 20), 64'd1);
    cycle(1'b1, rand_tile(), 1'b1);
    for (int k = 0; k < 10; k++) cycle(1'b0, z, 1'b1);

    // Backpressure mid-tile, then a dropped third tile.
    cycle(1'b1, rand_tile(), 1'b1);
    cycle(1'b0, z, 1'b1);
    cycle(1'b0, z, 1'b1);
    cycle(1'b1, rand_tile(), 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, z, 1'b0);
    cycle(1'b1, rand_tile(), 1'b0);
    for (int k = 0; k < 12; k++) cycle(1'b0, z, 1'b1);

    // Reset at row 2 of a tile, then a fresh tile drains from row 0.
    do_reset();
    cycle(1'b1, rand_tile(), 1'b1);
    cycle(1'b0, z, 1'b1);
    cycle(1'b0, z, 1'b1);
    do_reset();
    cycle(1'b1, rand_tile(), 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b0, z, 1'b1);

    // Randomised traffic with random backpressure.
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 2) == 0, rand_tile(), $urandom_range(0, 3) != 0);
    do_reset();
    for (int k = 0; k < 300; k++)
      cycle($urandom_range(0, 4) == 0, rand_tile(), $urandom_range(0, 5) != 0);

    // Final drain, bounded.
    guard = 0;
    while (m_tiles > 0 && guard < 40) begin
      cycle(1'b0, z, 1'b1);
      guard++;
    end
    cycle(1'b0, z, 1'b1);
    chk("drain_done", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_array_result_drain
`default_nettype wire
